packet_bigword_ram: RTL

Dual-bank packet buffer directly upstream of the CPU's read size adapter. A packet filler writes 32-bit big-endian words into it, then hands ownership to the CPU. The CPU presents one word address per cycle and receives, one cycle later, the 64-bit "bigword" {mem[a], mem[a+1]}. The adapter uses this bigword to extract unaligned byte, half-word and word loads. Storage is split into even and odd word banks so that both words are read in a single cycle.

---
 rtl/packet_bigword_ram_pkg.sv | 15 +
 rtl/packet_bigword_ram_if.sv | 42 ++++
 rtl/bpf_bank_ram.sv | 37 +++
 rtl/packet_bigword_ram.sv | 132 +++++++++++++
 4 files changed

// File: rtl/packet_bigword_ram_pkg.sv
// rtl/packet_bigword_ram_pkg.sv - shared definitions for the packet bigword buffer
//
// Package bpf_defs: ownership state encoding and the word size, shared with
// the CPU read size adapter so both sides agree on the same constants.
package bpf_defs;

  // Buffer ownership: FILL = packet filler owns it, READY = CPU owns it.
  typedef enum logic {
    ST_FILL  = 1'b0,
    ST_READY = 1'b1
  } bpf_state_e;

  localparam int BPF_WORD_BYTES = 4;

endpackage

// File: rtl/packet_bigword_ram_if.sv
// rtl/packet_bigword_ram_if.sv - filler/CPU bus bundle for the packet bigword buffer
//
// Signals:
//   wr_addr/wr_data/wr_en  filler word write (big-endian word, byte 0 in [31:24])
//   wr_done/wr_len         filler hand-off, packet length in bytes
//   filler_ready           buffer owned by the filler
//   rd_addr/rd_en          CPU word read request
//   rd_done                CPU releases the buffer
//   pkt_ready              buffer owned by the CPU
//   pkt_len                latched packet length
//   bigword                {mem[a], mem[a+1]} for the last accepted read
// Modports: master = filler/CPU side, slave = buffer side.
interface packet_bigword_ram_if #(
  parameter int BYTE_ADDR_WIDTH = 12
);

  logic [BYTE_ADDR_WIDTH-3:0] wr_addr;
  logic [31:0]                wr_data;
  logic                       wr_en;
  logic                       wr_done;
  logic [BYTE_ADDR_WIDTH:0]   wr_len;
  logic                       filler_ready;
  logic [BYTE_ADDR_WIDTH-3:0] rd_addr;
  logic                       rd_en;
  logic                       rd_done;
  logic                       pkt_ready;
  logic [BYTE_ADDR_WIDTH:0]   pkt_len;
  logic [63:0]                bigword;

  modport master (
    output wr_addr, wr_data, wr_en, wr_done, wr_len,
    output rd_addr, rd_en, rd_done,
    input  filler_ready, pkt_ready, pkt_len, bigword
  );

  modport slave (
    input  wr_addr, wr_data, wr_en, wr_done, wr_len,
    input  rd_addr, rd_en, rd_done,
    output filler_ready, pkt_ready, pkt_len, bigword
  );

endinterface

// File: rtl/bpf_bank_ram.sv
// rtl/bpf_bank_ram.sv - simple dual-port word RAM, one write port, one registered read port
//
// Ports:
//   clk    rising-edge clock
//   we     write enable; writes wdata to waddr
//   waddr  write index
//   wdata  write word
//   re     read enable; rdata loads mem[raddr] and otherwise holds
//   raddr  read index
//   rdata  registered read word
// No reset on storage or read register so the array maps onto block RAM.
module bpf_bank_ram #(
  parameter int DEPTH      = 512,
  parameter int DATA_WIDTH = 32,
  localparam int AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/packet_bigword_ram.sv
// rtl/packet_bigword_ram.sv - dual-bank packet buffer returning {mem[a], mem[a+1]} per read
//
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   bus    packet_bigword_ram_if.slave (filler write side, CPU read side,
//          ownership flags, packet length, bigword result)
// Words are split by address parity into an even and an odd bank so the
// two adjacent words of a bigword come out of different RAMs in one cycle.
module packet_bigword_ram
  import bpf_defs::*;
#(
  parameter int BYTE_ADDR_WIDTH = 12
) (
  input  logic                 clk,
  input  logic                 rst_n,
  packet_bigword_ram_if.slave  bus
);

  localparam int WA        = BYTE_ADDR_WIDTH - 2;   // word address bits
  localparam int BA        = BYTE_ADDR_WIDTH - 3;   // bank index bits
  localparam int DEPTH     = 1 << BA;
  localparam int WORD_BITS = BPF_WORD_BYTES * 8;

  bpf_state_e state_q, state_d;

  logic wr_accept;
  logic rd_accept;
  logic latch_len;

  logic [BYTE_ADDR_WIDTH:0] pkt_len_q;
  logic                     a0_q;          // parity of the read in the bank output registers
  logic                     out_clr_q;     // masks bank outputs until the first read after reset

  logic [BA-1:0]        wr_idx;
  logic [BA-1:0]        rd_h;
  logic [BA-1:0]        rd_h_inc;
  logic [BA-1:0]        even_rd_idx;
  logic [WORD_BITS-1:0] even_q;
  logic [WORD_BITS-1:0] odd_q;

  // Ownership FSM: writes only in FILL, reads only in READY.
  always_comb begin
    state_d   = state_q;
    wr_accept = 1'b0;
    rd_accept = 1'b0;
    latch_len = 1'b0;
    case (state_q)
      ST_FILL: begin
        wr_accept = bus.wr_en;
        if (bus.wr_done) begin
          latch_len = 1'b1;
          state_d   = ST_READY;
        end
      end
      ST_READY: begin
        rd_accept = bus.rd_en;
        if (bus.rd_done) begin
          state_d = ST_FILL;
        end
      end
      default: state_d = ST_FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_FILL;
      pkt_len_q <= '0;
      a0_q      <= 1'b0;
      out_clr_q <= 1'b1;
    end else begin
      state_q <= state_d;
      if (latch_len) begin
        pkt_len_q <= bus.wr_len;
      end
      if (rd_accept) begin
        a0_q      <= bus.rd_addr[0];
        out_clr_q <= 1'b0;
      end
    end
  end

  // Write side: parity picks the bank, the rest of the address is the index.
  assign wr_idx = bus.wr_addr[WA-1:1];

  // Read side: an odd address needs the next even word, which lives at h+1;
  // the BA-bit add wraps naturally so the last word pairs with word 0.
  assign rd_h        = bus.rd_addr[WA-1:1];
  assign rd_h_inc    = rd_h + BA'(1);
  assign even_rd_idx = bus.rd_addr[0] ? rd_h_inc : rd_h;

  bpf_bank_ram #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (WORD_BITS)
  ) u_even_bank (
    .clk   (clk),
    .we    (wr_accept & ~bus.wr_addr[0]),
    .waddr (wr_idx),
    .wdata (bus.wr_data),
    .re    (rd_accept),
    .raddr (even_rd_idx),
    .rdata (even_q)
  );

  bpf_bank_ram #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (WORD_BITS)
  ) u_odd_bank (
    .clk   (clk),
    .we    (wr_accept & bus.wr_addr[0]),
    .waddr (wr_idx),
    .wdata (bus.wr_data),
    .re    (rd_accept),
    .raddr (rd_h),
    .rdata (odd_q)
  );

  // Bank registers and a0_q only load on an accepted read, so the swap
  // result holds between reads without a separate output register.
  always_comb begin
    bus.bigword = '0;
    if (!out_clr_q) begin
      bus.bigword = a0_q ? {odd_q, even_q} : {even_q, odd_q};
    end
  end

  assign bus.filler_ready = (state_q == ST_FILL);
  assign bus.pkt_ready    = (state_q == ST_READY);
  assign bus.pkt_len      = pkt_len_q;

endmodule
